// File: rtl/msg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msg_pkg
//  Description : Shared definitions for the message arbiter: message length,
//                word type, message-ID constants and FSM state encoding.
//                MSG_LEN depends on MSG_ARBITER_FRAME_TAG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package msg_pkg;

`ifdef MSG_ARBITER_FRAME_TAG_EN
  // ID, two payload words, then the frame tag word
  localparam int MSG_LEN = 4;
`else
  // ID and two payload words
  localparam int MSG_LEN = 3;
`endif

  typedef logic [31:0] msg_word_t;

  // Message IDs: ASCII mnemonics, right-justified in word0
  localparam msg_word_t MSG_ID_RBB = 32'h0052_4242;  // "RBB"
  localparam msg_word_t MSG_ID_WBB = 32'h0057_4242;  // "WBB"
  localparam msg_word_t MSG_ID_CLR = 32'h0043_4C52;  // "CLR"

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/msg_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational round-robin picker. Returns the first active
//                request after index 'last', wrapping NUM_SRC-1 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select
  import msg_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         grant,
  output logic               valid
);

  logic [2:0] w_sum;

  // Scan from farthest to nearest candidate so the nearest one after 'last' wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_sum = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_sum = {1'b0, last} + 3'(k);
      if (w_sum >= 3'(NUM_SRC)) begin
        w_sum = w_sum - 3'(NUM_SRC);
      end
      if (req[w_sum[1:0]]) begin
        grant = w_sum[1:0];
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : msg_arbiter
//  Description : Round-robin arbiter moving fixed-length messages from
//                NUM_SRC producers into a downstream FIFO, one word per
//                cycle. Optional frame tag word enabled by defining
//                MSG_ARBITER_FRAME_TAG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_arbiter
  import msg_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_ready,
  input  logic [NUM_SRC*96-1:0] src_msg,
  input  logic [7:0]            fifo_usedw,
  input  logic                  flush,
  input  logic                  frame_tick,
  output logic                  fifo_wr,
  output logic [31:0]           fifo_data,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  // A message is only started when the whole message fits in the FIFO
  localparam logic [31:0] c_room_limit  = 32'(FIFO_DEPTH - MSG_LEN);
  localparam logic [1:0]  c_last_word   = 2'(MSG_LEN - 1);
  // Pointer resets to the top index so source 0 is first in line
  localparam logic [1:0]  c_reset_grant = 2'(NUM_SRC - 1);

  arb_state_t        r_state;
  msg_word_t         r_words [MSG_LEN];
  logic [1:0]        r_word_idx;

  logic [95:0]       w_msg_arr [NUM_SRC];
  logic [95:0]       w_sel_msg;
  logic [1:0]        w_pick;
  logic              w_pick_valid;
  logic              w_room;
  logic              w_accept;
  logic [NUM_SRC-1:0] w_onehot;

  // Split the flat message bus into one 96-bit entry per source
  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
      assign w_msg_arr[g] = src_msg[g*96 +: 96];
    end
  endgenerate

  rr_select #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_select (
    .req   (src_valid),
    .last  (grant_id),
    .grant (w_pick),
    .valid (w_pick_valid)
  );

  assign w_sel_msg = w_msg_arr[w_pick];
  assign w_room    = (32'(fifo_usedw) < c_room_limit);
  // flush has priority over a grantable request
  assign w_accept  = (r_state == ST_IDLE) && w_pick_valid && w_room && !flush;
  assign busy      = (r_state == ST_WRITE);

  // One-hot accept pulse for the picked source
  always_comb begin
    w_onehot = '0;
    w_onehot[w_pick] = 1'b1;
  end

`ifdef MSG_ARBITER_FRAME_TAG_EN
  logic [15:0] r_frame_cnt;

  // Free-running frame counter; independent of flush and of the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (frame_tick) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`else
  logic w_unused_frame_tick;
  assign w_unused_frame_tick = frame_tick;
`endif

  // Arbitration FSM: accept in IDLE, stream the latched words in WRITE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      fifo_wr    <= 1'b0;
      fifo_data  <= '0;
      src_ready  <= '0;
      grant_id   <= c_reset_grant;
      for (int k = 0; k < MSG_LEN; k++) begin
        r_words[k] <= '0;
      end
    end else begin
      src_ready <= '0;
      fifo_wr   <= 1'b0;
      if (flush) begin
        // Abandon any partial message; the pointer in grant_id is kept
        r_state    <= ST_IDLE;
        r_word_idx <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              src_ready  <= w_onehot;
              grant_id   <= w_pick;
              r_word_idx <= '0;
              r_state    <= ST_WRITE;
              for (int k = 0; k < 3; k++) begin
                r_words[k] <= w_sel_msg[k*32 +: 32];
              end
`ifdef MSG_ARBITER_FRAME_TAG_EN
              r_words[3] <= {16'h0000, r_frame_cnt};
`endif
            end
          end
          ST_WRITE: begin
            fifo_wr   <= 1'b1;
            fifo_data <= r_words[r_word_idx];
            if (r_word_idx == c_last_word) begin
              r_word_idx <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_word_idx <= r_word_idx + 2'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_arbiter
//  Description : Directed self-checking bench for msg_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_msg_arbiter;

`ifdef MSG_ARBITER_FRAME_TAG_EN
  localparam int c_msg_len = 4;
`else
  localparam int c_msg_len = 3;
`endif
  localparam int c_num_src = 3;
  // Highest fill level at which a message may still start (256 - len - 1)
  localparam int c_room_max = 256 - c_msg_len - 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [c_num_src-1:0]    src_valid;
  logic [c_num_src-1:0]    src_ready;
  logic [c_num_src*96-1:0] src_msg;
  logic [7:0]              fifo_usedw;
  logic                    flush;
  logic                    frame_tick;
  logic                    fifo_wr;
  logic [31:0]             fifo_data;
  logic                    busy;
  logic [1:0]              grant_id;

  logic [31:0] stim [c_num_src][3];
  int checks   = 0;
  int failures = 0;

  msg_arbiter #(
    .NUM_SRC    (c_num_src),
    .FIFO_DEPTH (256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_msg    (src_msg),
    .fifo_usedw (fifo_usedw),
    .flush      (flush),
    .frame_tick (frame_tick),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_msgs();
    for (int i = 0; i < c_num_src; i++) begin
      for (int k = 0; k < 3; k++) begin
        src_msg[i*96 + k*32 +: 32] = stim[i][k];
      end
    end
  endtask

  // Expected word k of a message from source s (tag word is 0 with no ticks)
  function automatic logic [31:0] exp_word(int s, int k);
    if (k < 3) return stim[s][k];
    return 32'h0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; src_valid = '0; flush = 1'b0; frame_tick = 1'b0;
    fifo_usedw = 8'd0; src_msg = '0;
    step(); step();
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_fifo_wr got=%b exp=0", fifo_wr); end
    checks++; if (fifo_data !== 32'h0) begin failures++; $display("FAIL reset_fifo_data got=%h exp=0", fifo_data); end
    checks++; if (src_ready !== 3'b000) begin failures++; $display("FAIL reset_src_ready got=%b exp=000", src_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL reset_grant_id got=%0d exp=2", grant_id); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    stim[0][0] = 32'h0052_4242; stim[0][1] = 32'h0020_0150; stim[0][2] = 32'h0;
    load_msgs();
    src_valid = 3'b001;
    step();
    checks++; if (src_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", src_ready); end
    checks++; if (busy !== 1'b1 || fifo_wr !== 1'b0) begin failures++; $display("FAIL single_accept_state busy=%b wr=%b exp busy=1 wr=0", busy, fifo_wr); end
    src_valid = 3'b000;
    for (int k = 0; k < c_msg_len; k++) begin
      step();
      checks++;
      if ({fifo_wr, fifo_data} !== {1'b1, exp_word(0, k)}) begin
        failures++; $display("FAIL single_word%0d got wr=%b data=%h exp wr=1 data=%h", k, fifo_wr, fifo_data, exp_word(0, k));
      end
      checks++; if (src_ready !== 3'b000) begin failures++; $display("FAIL single_ready_low%0d got=%b exp=000", k, src_ready); end
    end
    step();
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_end got wr=%b busy=%b exp 0 0", fifo_wr, busy); end
  endtask

  task automatic test_contention();
    int order [4] = '{0, 1, 2, 0};
    int s;
    do_reset();
    for (int i = 0; i < c_num_src; i++) begin
      for (int k = 0; k < 3; k++) begin
        stim[i][k] = 32'hA000_0000 | (i << 8) | k;
      end
    end
    load_msgs();
    src_valid = 3'b111;
    for (int m = 0; m < 4; m++) begin
      s = order[m];
      step();
      checks++;
      if (src_ready !== 3'(1 << s) || grant_id !== 2'(s)) begin
        failures++; $display("FAIL contention_grant%0d got ready=%b id=%0d exp src=%0d", m, src_ready, grant_id, s);
      end
      if (m > 0) begin
        checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL contention_gap%0d got wr=%b exp=0", m, fifo_wr); end
      end
      if (m == 3) src_valid = 3'b000;
      for (int k = 0; k < c_msg_len; k++) begin
        step();
        checks++;
        if ({fifo_wr, fifo_data} !== {1'b1, exp_word(s, k)}) begin
          failures++; $display("FAIL contention_m%0d_w%0d got wr=%b data=%h exp data=%h", m, k, fifo_wr, fifo_data, exp_word(s, k));
        end
      end
    end
    step();
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL contention_end got wr=%b busy=%b exp 0 0", fifo_wr, busy); end
  endtask

  task automatic test_fifo_full();
    src_valid = 3'b010;
    fifo_usedw = 8'(c_room_max + 1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (src_ready !== 3'b000 || busy !== 1'b0) begin
        failures++; $display("FAIL full_hold%0d got ready=%b busy=%b exp 000 0", i, src_ready, busy);
      end
    end
    // Request withdrawn before it could be accepted
    src_valid = 3'b000;
    fifo_usedw = 8'(c_room_max);
    step();
    checks++; if (src_ready !== 3'b000 || grant_id !== 2'd0) begin failures++; $display("FAIL full_withdraw got ready=%b id=%0d exp 000 0", src_ready, grant_id); end
    src_valid = 3'b010;
    fifo_usedw = 8'(c_room_max + 1);
    step();
    checks++; if (src_ready !== 3'b000) begin failures++; $display("FAIL full_block got=%b exp=000", src_ready); end
    fifo_usedw = 8'(c_room_max);
    step();
    checks++; if (src_ready !== 3'b010 || grant_id !== 2'd1) begin failures++; $display("FAIL full_release got ready=%b id=%0d exp 010 1", src_ready, grant_id); end
    src_valid = 3'b000;
    for (int k = 0; k < c_msg_len; k++) begin
      step();
      checks++;
      if ({fifo_wr, fifo_data} !== {1'b1, exp_word(1, k)}) begin
        failures++; $display("FAIL full_word%0d got wr=%b data=%h exp data=%h", k, fifo_wr, fifo_data, exp_word(1, k));
      end
    end
    step();
    fifo_usedw = 8'd0;
  endtask

  task automatic test_flush();
    src_valid = 3'b111;
    step();
    checks++; if (src_ready !== 3'b100 || grant_id !== 2'd2) begin failures++; $display("FAIL flush_grant got ready=%b id=%0d exp 100 2", src_ready, grant_id); end
    src_valid = 3'b000;
    step();
    checks++; if ({fifo_wr, fifo_data} !== {1'b1, stim[2][0]}) begin failures++; $display("FAIL flush_word0 got wr=%b data=%h exp %h", fifo_wr, fifo_data, stim[2][0]); end
    step();
    checks++; if ({fifo_wr, fifo_data} !== {1'b1, stim[2][1]}) begin failures++; $display("FAIL flush_word1 got wr=%b data=%h exp %h", fifo_wr, fifo_data, stim[2][1]); end
    flush = 1'b1;
    step();
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_abort got wr=%b busy=%b exp 0 0", fifo_wr, busy); end
    flush = 1'b0;
    step();
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL flush_no_resume got wr=%b exp=0", fifo_wr); end
    src_valid = 3'b111;
    step();
    checks++; if (src_ready !== 3'b001 || grant_id !== 2'd0) begin failures++; $display("FAIL flush_next_grant got ready=%b id=%0d exp 001 0", src_ready, grant_id); end
    src_valid = 3'b000;
    repeat (c_msg_len + 1) step();
    // Flush coinciding with a grantable request blocks the accept
    src_valid = 3'b010;
    flush = 1'b1;
    step();
    checks++; if (src_ready !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL flush_wins got ready=%b busy=%b exp 000 0", src_ready, busy); end
    flush = 1'b0;
    step();
    checks++; if (src_ready !== 3'b010) begin failures++; $display("FAIL flush_after got ready=%b exp=010", src_ready); end
    src_valid = 3'b000;
    repeat (c_msg_len + 1) step();
  endtask

  task automatic test_reset_mid_write();
    src_valid = 3'b100;
    step();
    checks++; if (src_ready !== 3'b100) begin failures++; $display("FAIL rstmid_grant got=%b exp=100", src_ready); end
    src_valid = 3'b000;
    step();
    checks++; if (fifo_wr !== 1'b1) begin failures++; $display("FAIL rstmid_writing got wr=%b exp=1", fifo_wr); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (fifo_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_async got wr=%b busy=%b exp 0 0", fifo_wr, busy); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL rstmid_ptr got=%0d exp=2", grant_id); end
    step();
    checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL rstmid_held got wr=%b exp=0", fifo_wr); end
    reset = 1'b0;
    src_valid = 3'b111;
    step();
    checks++; if (src_ready !== 3'b001) begin failures++; $display("FAIL rstmid_first got=%b exp=001", src_ready); end
    src_valid = 3'b000;
    repeat (c_msg_len + 1) step();
  endtask

`ifdef MSG_ARBITER_FRAME_TAG_EN
  task automatic test_frame_tag();
    frame_tick = 1'b1;
    repeat (3) step();
    frame_tick = 1'b0;
    src_valid = 3'b001;
    step();
    src_valid = 3'b000;
    repeat (4) step();
    checks++; if ({fifo_wr, fifo_data} !== {1'b1, 32'h0000_0003}) begin failures++; $display("FAIL tag_three got wr=%b data=%h exp 00000003", fifo_wr, fifo_data); end
    step();
    // Remaining ticks to reach 0x10000 total; flush during some must not matter
    frame_tick = 1'b1;
    flush = 1'b1;
    repeat (10) step();
    flush = 1'b0;
    repeat (65536 - 3 - 10) step();
    frame_tick = 1'b0;
    src_valid = 3'b010;
    step();
    src_valid = 3'b000;
    repeat (4) step();
    checks++; if ({fifo_wr, fifo_data} !== {1'b1, 32'h0000_0000}) begin failures++; $display("FAIL tag_wrap got wr=%b data=%h exp 00000000", fifo_wr, fifo_data); end
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < c_num_src; i++) begin
      for (int k = 0; k < 3; k++) stim[i][k] = 32'h0;
    end
    test_reset();
    test_single();
    test_contention();
    test_fifo_full();
    test_flush();
    test_reset_mid_write();
`ifdef MSG_ARBITER_FRAME_TAG_EN
    test_frame_tag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msg_arbiter.md
MSG_ARBITER -- requirements
Module: msg_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of message producers (2..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 256: word capacity of the downstream message FIFO.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port src_valid  input  NUM_SRC  per-source message request; held until accepted.
REQ-006 SHALL have port src_ready  output  NUM_SRC  one-cycle accept pulse per source.
REQ-007 SHALL have port src_msg  input  NUM_SRC*96  per-source message: word0 = ID (bits 31:0), word1, word2.
REQ-008 SHALL have port fifo_usedw  input  8  current FIFO fill level.
REQ-009 SHALL have port flush  input  1  synchronous abort of the message in flight.
REQ-010 SHALL have port frame_tick  input  1  one-cycle end-of-video-frame pulse.
REQ-011 SHALL have port fifo_wr  output  1  FIFO write strobe, registered.
REQ-012 SHALL have port fifo_data  output  32  FIFO write word, registered.
REQ-013 SHALL have port busy  output  1  high while not in IDLE.
REQ-014 SHALL have port grant_id  output  2  index of the source currently or most recently granted.

Function
REQ-015 SHALL implement FSM states IDLE and WRITE.
REQ-016 In IDLE, SHALL accept one valid source when fifo_usedw < FIFO_DEPTH - MSG_LEN and flush is low.
REQ-017 SHALL select round-robin: first valid source after the last granted index, wrapping NUM_SRC-1 -> 0.
REQ-018 On accept (cycle N): SHALL pulse src_ready[i] for cycle N only, latch src_msg[i] and grant_id, and go to WRITE.
REQ-019 In WRITE: SHALL assert fifo_wr for exactly MSG_LEN consecutive cycles, N+1..N+MSG_LEN, with words in order 0..MSG_LEN-1.
REQ-020 After the last word: SHALL return to IDLE; the earliest next accept is cycle N+MSG_LEN+1.
REQ-021 SHALL never accept a source while in WRITE; src_ready SHALL be all-zero outside accept cycles.
REQ-022 If src_valid deasserts before acceptance: SHALL issue no message for that source and SHALL leave the pointer unchanged.
REQ-023 When the FIFO room check fails: SHALL stay in IDLE with src_ready low; requests are held, never dropped.
REQ-024 flush in any state: the next cycle SHALL have fifo_wr=0 and state IDLE; a partial message is abandoned; the round-robin pointer is retained.
REQ-025 When flush and a grantable request coincide, flush SHALL win and no accept SHALL occur.
REQ-026 frame_cnt (16 bit) SHALL increment on frame_tick, wrap 0xFFFF -> 0x0000, and be unaffected by flush.

Reset
REQ-027 While reset is high: state=IDLE, fifo_wr=0, fifo_data=0, src_ready=0, busy=0, grant_id=NUM_SRC-1 (so source 0 wins first), frame_cnt=0.
REQ-028 Reset asserted mid-WRITE SHALL abandon the message immediately; no further words written.

Configuration
REQ-029 With MSG_ARBITER_FRAME_TAG_EN defined: MSG_LEN=4, appending word3 = {16'h0, frame_cnt} sampled at accept.
REQ-030 Without MSG_ARBITER_FRAME_TAG_EN: MSG_LEN=3; frame_cnt is not implemented; frame_tick is ignored.

Structure
REQ-031 Shared package msg_pkg SHALL hold MSG_LEN, the message word type, message-ID constants ("RBB" etc.) and the FSM state enum.
REQ-032 SHALL contain one sub-module, rr_select: a combinational round-robin picker taking request vector and last index, returning grant index and valid.

Verification
REQ-033 Single request: src_valid=3'b001, usedw=0, msg={"RBB",0x00200150,0} -> src_ready[0] pulse at N; fifo_wr at N+1..N+3 with those words; busy low at N+4.
REQ-034 Contention: src_valid=3'b111 held -> grant order 0,1,2,0; each message is MSG_LEN contiguous words; one idle cycle between messages.
REQ-035 FIFO full: usedw=253 (MSG_LEN=3) -> no accept; lower to 252 -> accept the next cycle.
REQ-036 Flush: assert flush on the 2nd word cycle -> fifo_wr=0 the next cycle, state IDLE, only 2 words written, next grant follows the pointer.
REQ-037 Reset: assert reset mid-WRITE -> fifo_wr drops asynchronously; after release, src 0 is granted first.
REQ-038 Frame tag (macro on): 3 frame_tick pulses then accept -> word3=0x00000003; 0x10000 ticks wrap frame_cnt to 0.
